// File: rtl/edge_serializer_if.sv
// Batch-in / edge-out handshake bundle for the edge serializer.
// slave is the serializer's view, master is the upstream/downstream environment.
interface edge_serializer_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic [W-1:0] in_e1;
  logic [W-1:0] in_e2;
  logic [W-1:0] in_e3;
  logic [W-1:0] in_e4;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_edge;
  logic         out_last;
  logic         out_ready;
  logic         busy;

  modport slave (
    input  in_valid, in_e1, in_e2, in_e3, in_e4, out_ready,
    output in_ready, out_valid, out_edge, out_last, busy
  );

  modport master (
    output in_valid, in_e1, in_e2, in_e3, in_e4, out_ready,
    input  in_ready, out_valid, out_edge, out_last, busy
  );
endinterface

// File: rtl/edge_serializer.sv
// Two-deep buffer of sorted 4-edge batches, issued one non-null edge per transfer.
// Null slots are skipped in a single step; an all-null batch retires with no output.
module edge_serializer #(
  parameter int           W         = 32,
  parameter logic [W-1:0] NULL_EDGE = {W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_n,
  edge_serializer_if.slave  sif
);

  logic [W-1:0] data [2][4];
  logic [3:0]   mask [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   idx;

  logic [W-1:0] in_edges [4];
  logic [3:0]   in_mask;
  logic [3:0]   head_mask;
  logic [3:0]   above;
  logic [1:0]   next_idx;
  logic         head_live;
  logic         accept;
  logic         advance;
  logic         pop;

  assign in_edges[0] = sif.in_e1;
  assign in_edges[1] = sif.in_e2;
  assign in_edges[2] = sif.in_e3;
  assign in_edges[3] = sif.in_e4;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      in_mask[k] = (in_edges[k] != NULL_EDGE);
    end
  end

  // above = set mask bits strictly after idx; next_idx is the lowest of them
  always_comb begin
    head_mask = mask[rd_ptr];
    above     = 4'b0000;
    case (idx)
      2'd0:    above = head_mask & 4'b1110;
      2'd1:    above = head_mask & 4'b1100;
      2'd2:    above = head_mask & 4'b1000;
      default: above = 4'b0000;
    endcase
    if (above[1])      next_idx = 2'd1;
    else if (above[2]) next_idx = 2'd2;
    else               next_idx = 2'd3;
  end

  assign head_live = (count != 2'd0) && head_mask[idx];
  // a null head slot moves on by itself; a live one waits for the consumer
  assign advance   = (count != 2'd0) && (!head_mask[idx] || sif.out_ready);
  assign pop       = advance && (above == 4'b0000);
  assign accept    = sif.in_valid && sif.in_ready;

  assign sif.in_ready  = (count < 2'd2);
  assign sif.out_valid = head_live;
  assign sif.out_edge  = head_live ? data[rd_ptr][idx] : '0;
  assign sif.out_last  = head_live && (above == 4'b0000);
  assign sif.busy      = (count != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      idx     <= 2'd0;
      mask[0] <= 4'b0000;
      mask[1] <= 4'b0000;
    end else begin
      if (accept) begin
        mask[wr_ptr] <= in_mask;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        idx    <= 2'd0;
      end else if (advance) begin
        idx <= next_idx;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // edge payload is qualified by the masks, so it carries no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 4; k++) begin
        data[wr_ptr][k] <= in_edges[k];
      end
    end
  end

endmodule

// File: tb/tb_edge_serializer.sv
// Self-checking bench for edge_serializer: directed scenarios plus random traffic,
// compared every cycle against a slot-queue reference model.
module tb_edge_serializer;

  localparam logic [31:0] NUL = 32'hFFFF_FFFF;

  logic clk;
  logic reset_n;

  edge_serializer_if #(.W(32)) sif ();

  edge_serializer #(.W(32), .NULL_EDGE(NUL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one entry per cycle-visit of a head slot. Position 0 is always
  // visited; later positions only if non-null. Null visits retire on their own.
  typedef struct {
    logic [31:0] e;
    bit          nul;
    bit          last;
    bit          eob;
  } slot_t;

  slot_t q[$];
  int    nb;
  int    n_cmp;
  int    n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic push_batch(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
    logic [31:0] e [4];
    int ln;
    int fin;
    slot_t s;
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    ln = -1;
    for (int k = 0; k < 4; k++) if (e[k] != NUL) ln = k;
    fin = (ln < 0) ? 0 : ln;
    for (int k = 0; k <= fin; k++) begin
      if (k == 0 || e[k] != NUL) begin
        s.e    = e[k];
        s.nul  = (e[k] == NUL);
        s.last = (k == ln);
        s.eob  = (k == fin);
        q.push_back(s);
      end
    end
    nb++;
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (q.size() > 0) && !q[0].nul;
    chk("out_valid", 32'(sif.out_valid), 32'(ev));
    chk("out_edge",  sif.out_edge, ev ? q[0].e : 32'h0);
    chk("out_last",  32'(sif.out_last), 32'(ev && q[0].last));
    chk("in_ready",  32'(sif.in_ready), 32'(nb < 2));
    chk("busy",      32'(sif.busy), 32'(nb > 0));
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d, input bit r);
    sif.in_valid  = v;
    sif.in_e1     = a;
    sif.in_e2     = b;
    sif.in_e3     = c;
    sif.in_e4     = d;
    sif.out_ready = r;
  endtask

  // Called at a negedge with inputs already driven: check, update model, advance one clock.
  task automatic step();
    bit acc;
    #1;
    check_outputs();
    acc = sif.in_valid && (nb < 2);
    if (q.size() > 0 && (q[0].nul || sif.out_ready)) begin
      if (q[0].eob) nb--;
      void'(q.pop_front());
    end
    if (acc) push_batch(sif.in_e1, sif.in_e2, sif.in_e3, sif.in_e4);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, $urandom, $urandom, $urandom, $urandom, r);
      step();
    end
  endtask

  task automatic mid_reset();
    reset_n = 1'b0;
    #1;
    q.delete();
    nb = 0;
    check_outputs();
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_edge();
    if ($urandom_range(0, 3) == 0) return NUL;
    return $urandom & 32'h7FFF_FFFF;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nb    = 0;
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // single full batch, free-running consumer
    drive(1'b1, 32'd10, 32'd20, 32'd30, 32'd40, 1'b1);
    step();
    idle(6, 1'b1);

    // nulls in the middle collapse without a bubble
    drive(1'b1, 32'd5, NUL, NUL, 32'd9, 1'b1);
    step();
    idle(4, 1'b1);

    // all-null batch followed by a full one
    drive(1'b1, NUL, NUL, NUL, NUL, 1'b1);
    step();
    drive(1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
    step();
    idle(6, 1'b1);

    // back-pressure: three batches offered with consumer stalled
    drive(1'b1, 32'd100, 32'd101, 32'd102, 32'd103, 1'b0);
    step();
    drive(1'b1, 32'd200, 32'd201, 32'd202, 32'd203, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd300 + 32'(i), 32'd301, 32'd302, 32'd303, 1'b0);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'd300, 32'd301, 32'd302, 32'd303, 1'b1);
      step();
    end
    idle(14, 1'b1);

    // consumer toggling
    drive(1'b1, 32'd7, 32'd8, 32'd9, 32'd10, 1'b1);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, (i % 2) == 0);
      step();
    end

    // reset after two edges of a batch have gone out
    drive(1'b1, 32'd50, 32'd51, 32'd52, 32'd53, 1'b1);
    step();
    idle(2, 1'b1);
    mid_reset();
    drive(1'b1, 32'd11, 32'd12, 32'd13, 32'd14, 1'b1);
    step();
    idle(6, 1'b1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 2) != 0, rnd_edge(), rnd_edge(), rnd_edge(), rnd_edge(),
            $urandom_range(0, 3) != 0);
      step();
      if (i == 1000) mid_reset();
    end
    idle(12, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
